// File: rtl/data_mem_rv.sv
// data_mem_rv: byte-addressable data memory for the RV32I load/store path.
// Accepts one request per cycle over a valid/ready handshake and returns a
// registered response one cycle later. Sub-word loads are lane-selected and
// extended. Misaligned, illegal-funct3 and out-of-range accesses return
// err=1 and have no side effect.
module data_mem_rv #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   state_t        state_r;
   logic          resp_valid_r;
   logic [31:0]   resp_rdata_r;
   logic          resp_err_r;

   // Word storage; lanes are written individually, contents are never reset.
   logic [31:0]   mem_r [DEPTH_WORDS];

   logic          accept_s;
   logic          legal_s;
   logic          misalign_s;
   logic          range_err_s;
   logic          err_s;
   logic [AW-1:0] word_idx_s;
   logic [3:0]    lane_en_s;
   logic [31:0]   wr_word_s;
   logic [31:0]   rd_word_s;
   logic [7:0]    rd_byte_s;
   logic [15:0]   rd_half_s;
   logic [31:0]   load_data_s;
   logic [31:0]   resp_data_s;

   // A new request can enter whenever the single response slot is free or
   // is being drained this same cycle; nothing enters during reset.
   assign req_ready  = rst_n && (!resp_valid_r || resp_ready);
   assign accept_s   = req_valid && req_ready;
   assign word_idx_s = req_addr[AW+1:2];
   assign rd_word_s  = mem_r[word_idx_s];

   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign resp_err   = resp_err_r;

   // Classify the request: funct3 legality, alignment and address range.
   always_comb begin
      legal_s     = 1'b0;
      misalign_s  = 1'b0;
      range_err_s = |(req_addr >> (AW + 2));
      case (req_funct3)
         3'b000: begin
            legal_s    = 1'b1;
            misalign_s = 1'b0;
         end
         3'b001: begin
            legal_s    = 1'b1;
            misalign_s = req_addr[0];
         end
         3'b010: begin
            legal_s    = 1'b1;
            misalign_s = |req_addr[1:0];
         end
         3'b100: begin
            legal_s    = !req_we;
            misalign_s = 1'b0;
         end
         3'b101: begin
            legal_s    = !req_we;
            misalign_s = req_addr[0];
         end
         default: begin
            legal_s    = 1'b0;
            misalign_s = 1'b0;
         end
      endcase
      err_s = !legal_s || misalign_s || range_err_s;
   end

   // Store lane enables and the store data replicated onto every lane.
   always_comb begin
      lane_en_s = 4'b0000;
      wr_word_s = req_wdata;
      case (req_funct3)
         3'b000: begin
            lane_en_s = 4'b0001 << req_addr[1:0];
            wr_word_s = {4{req_wdata[7:0]}};
         end
         3'b001: begin
            lane_en_s = req_addr[1] ? 4'b1100 : 4'b0011;
            wr_word_s = {2{req_wdata[15:0]}};
         end
         3'b010: begin
            lane_en_s = 4'b1111;
            wr_word_s = req_wdata;
         end
         default: begin
            lane_en_s = 4'b0000;
            wr_word_s = req_wdata;
         end
      endcase
   end

   // Pick the addressed lane(s) from the read word and extend to 32 bits.
   always_comb begin
      rd_byte_s   = 8'h00;
      load_data_s = 32'h0000_0000;
      case (req_addr[1:0])
         2'b00:   rd_byte_s = rd_word_s[7:0];
         2'b01:   rd_byte_s = rd_word_s[15:8];
         2'b10:   rd_byte_s = rd_word_s[23:16];
         2'b11:   rd_byte_s = rd_word_s[31:24];
         default: rd_byte_s = 8'h00;
      endcase
      rd_half_s = req_addr[1] ? rd_word_s[31:16] : rd_word_s[15:0];
      case (req_funct3)
         3'b000:  load_data_s = {{24{rd_byte_s[7]}}, rd_byte_s};
         3'b001:  load_data_s = {{16{rd_half_s[15]}}, rd_half_s};
         3'b010:  load_data_s = rd_word_s;
         3'b100:  load_data_s = {24'h00_0000, rd_byte_s};
         3'b101:  load_data_s = {16'h0000, rd_half_s};
         default: load_data_s = 32'h0000_0000;
      endcase
      resp_data_s = (err_s || req_we) ? 32'h0000_0000 : load_data_s;
   end

   // Commit enabled store lanes on the accept edge of an error-free store.
   always_ff @(posedge clk) begin
      if (accept_s && req_we && !err_s) begin
         for (int k = 0; k < 4; k++) begin
            if (lane_en_s[k]) begin
               mem_r[word_idx_s][8*k +: 8] <= wr_word_s[8*k +: 8];
            end
         end
      end
   end

   // Response FSM: load a response on accept, hold it under backpressure,
   // retire it when the consumer takes it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  state_r      <= ST_RESP;
                  resp_valid_r <= 1'b1;
                  resp_rdata_r <= resp_data_s;
                  resp_err_r   <= err_s;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  if (accept_s) begin
                     state_r      <= ST_RESP;
                     resp_valid_r <= 1'b1;
                     resp_rdata_r <= resp_data_s;
                     resp_err_r   <= err_s;
                  end else begin
                     state_r      <= ST_IDLE;
                     resp_valid_r <= 1'b0;
                  end
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               resp_valid_r <= 1'b0;
               resp_rdata_r <= 32'h0000_0000;
               resp_err_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_rv.sv
// tb_data_mem_rv: directed and randomized checks of data_mem_rv against a
// byte-array reference model of the load/store rules.
module tb_data_mem_rv;

   localparam int DEPTH = 256;
   localparam int NBYTES = 4 * DEPTH;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // reference model state
   logic        m_valid;
   logic [31:0] m_rdata;
   logic        m_err;
   logic [7:0]  mbytes [NBYTES];

   always #5 clk = ~clk;

   data_mem_rv #(.DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int acc_bytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
      if (we) begin
         if (!(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
      end else begin
         if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      end
      if ((a % acc_bytes(f3)) != 0) return 1'b1;
      if (a >= 32'(NBYTES)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      int n;
      v = 32'd0;
      n = acc_bytes(f3);
      for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[a + 32'(i)];
      if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   // reference model: advance on every rising edge from the bench's own inputs
   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_rdata <= 32'd0;
         m_err   <= 1'b0;
      end else if (req_valid && (!m_valid || resp_ready)) begin
         m_valid <= 1'b1;
         if (model_err(req_we, req_funct3, req_addr)) begin
            m_err   <= 1'b1;
            m_rdata <= 32'd0;
         end else begin
            m_err <= 1'b0;
            if (req_we) begin
               m_rdata <= 32'd0;
               for (int i = 0; i < acc_bytes(req_funct3); i++)
                  mbytes[req_addr + 32'(i)] <= req_wdata[8*i +: 8];
            end else begin
               m_rdata <= model_load(req_funct3, req_addr);
            end
         end
      end else if (m_valid && resp_ready) begin
         m_valid <= 1'b0;
      end
   end

   // compare process: check DUT outputs against the model every cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", {31'd0, req_ready}, {31'd0, rst_n && (!m_valid || resp_ready)});
         chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
         if (m_valid) begin
            chk("resp_rdata", resp_rdata, m_rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
         end
      end
   end

   task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
   endtask

   // one request, wait (bounded) for accept, return the response fields
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int k;
      @(posedge clk); #2;
      drive(we, f3, a, wd);
      resp_ready = 1'b1;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout: got no req_ready expected req_ready=1");
      end
      @(posedge clk); #2;
      req_valid = 1'b0;
      @(negedge clk);
      chk("req_resp_valid", {31'd0, resp_valid}, 32'd1);
      rd = resp_rdata;
      er = resp_err;
   endtask

   logic [31:0] rd;
   logic        er;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
      for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b1;

      // fill the array so every later load has defined contents
      for (int w = 0; w < DEPTH; w++) do_req(1'b1, 3'd2, 32'(4 * w), $urandom, rd, er);

      // reset pulse, then SW/LW back-to-back on the first live edge
      @(posedge clk); #2; rst_n = 1'b0;
      @(posedge clk); #2;
      @(negedge clk);
      chk("rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      drive(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      @(posedge clk); #2;
      drive(1'b0, 3'd2, 32'h10, 32'h0);
      @(negedge clk);
      chk("sw_resp_rdata", resp_rdata, 32'd0);
      chk("sw_resp_err", {31'd0, resp_err}, 32'd0);
      @(posedge clk); #2;
      req_valid = 1'b0;
      @(negedge clk);
      chk("lw_after_sw_valid", {31'd0, resp_valid}, 32'd1);
      chk("lw_after_sw", resp_rdata, 32'hDEADBEEF);

      // sub-word stores and loads
      do_req(1'b1, 3'd2, 32'h20, 32'h8899AABB, rd, er);
      do_req(1'b1, 3'd0, 32'h21, 32'h00000011, rd, er);
      chk("sb_rdata", rd, 32'd0);
      do_req(1'b0, 3'd2, 32'h20, 32'h0, rd, er); chk("lw_after_sb", rd, 32'h889911BB);
      chk("model_pin_sb", model_load(3'd2, 32'h20), 32'h889911BB);
      do_req(1'b0, 3'd0, 32'h23, 32'h0, rd, er); chk("lb", rd, 32'hFFFFFF88);
      do_req(1'b0, 3'd4, 32'h23, 32'h0, rd, er); chk("lbu", rd, 32'h00000088);
      do_req(1'b0, 3'd1, 32'h22, 32'h0, rd, er); chk("lh", rd, 32'hFFFF8899);
      do_req(1'b0, 3'd5, 32'h20, 32'h0, rd, er); chk("lhu", rd, 32'h000011BB);
      chk("model_pin_lh", model_load(3'd1, 32'h22), 32'hFFFF8899);

      // error cases leave the word at 0x30 untouched
      do_req(1'b1, 3'd2, 32'h30, 32'h13572468, rd, er);
      for (int e = 0; e < 5; e++) begin
         case (e)
            0: do_req(1'b0, 3'd2, 32'h31, 32'h0, rd, er);
            1: do_req(1'b1, 3'd1, 32'h33, 32'hFFFF, rd, er);
            2: do_req(1'b1, 3'd2, 32'h400, 32'hFFFFFFFF, rd, er);
            3: do_req(1'b1, 3'd2, 32'h430, 32'hFFFFFFFF, rd, er);
            default: do_req(1'b0, 3'd3, 32'h30, 32'h0, rd, er);
         endcase
         chk("err_flag", {31'd0, er}, 32'd1);
         chk("err_rdata", rd, 32'd0);
         do_req(1'b0, 3'd2, 32'h30, 32'h0, rd, er);
         chk("err_no_write", rd, 32'h13572468);
      end

      // back-to-back word loads
      for (int i = 0; i < 8; i++) do_req(1'b1, 3'd2, 32'h40 + 32'(4 * i), 32'hA5000000 + 32'(i), rd, er);
      @(posedge clk); #2;
      drive(1'b0, 3'd2, 32'h40, 32'h0);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #2;
         if (i < 7) drive(1'b0, 3'd2, 32'h40 + 32'(4 * (i + 1)), 32'h0);
         else req_valid = 1'b0;
         @(negedge clk);
         chk("b2b_valid", {31'd0, resp_valid}, 32'd1);
         chk("b2b_rdata", resp_rdata, 32'hA5000000 + 32'(i));
      end

      // backpressure: held response, stalled store ignored
      do_req(1'b1, 3'd2, 32'h50, 32'h0BADF00D, rd, er);
      @(posedge clk); #2;
      drive(1'b0, 3'd2, 32'h10, 32'h0);
      @(posedge clk); #2;
      resp_ready = 1'b0;
      drive(1'b1, 3'd2, 32'h50, 32'hBAD0BAD0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, resp_valid}, 32'd1);
         chk("bp_rdata", resp_rdata, 32'hDEADBEEF);
         chk("bp_ready", {31'd0, req_ready}, 32'd0);
         if (j < 2) @(posedge clk);
      end
      @(posedge clk); #2;
      resp_ready = 1'b1;
      drive(1'b0, 3'd2, 32'h50, 32'h0);
      @(negedge clk);
      chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #2;
      req_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_store_ignored", resp_rdata, 32'h0BADF00D);

      // reset while a response is pending
      @(posedge clk); #2;
      drive(1'b0, 3'd2, 32'h20, 32'h0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      drive(1'b1, 3'd2, 32'h10, 32'h0);
      @(negedge clk);
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #2;
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("mid_rst_ready2", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      req_valid = 1'b0;
      do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er);
      chk("after_rst_mem", rd, 32'hDEADBEEF);

      // randomized traffic, checked by the compare process
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         req_valid  = ($urandom_range(0, 3) != 0);
         req_we     = 1'($urandom_range(0, 1));
         req_funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                                  : 3'($urandom_range(0, 2) + (($urandom_range(0, 3) == 0) ? 4 : 0));
         case ($urandom_range(0, 15))
            0:       req_addr = $urandom;
            1, 2, 3: req_addr = 32'($urandom_range(0, NBYTES - 1));
            default: req_addr = 32'($urandom_range(0, 127));
         endcase
         req_wdata  = $urandom;
         resp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #2;
      req_valid = 1'b0;
      resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
